// File: rtl/aegnn_pkg.sv
// Shared types and widths for the GNN feature-by-weight multiplier.
package aegnn;

  localparam int unsigned F_WIDTH    = 8;
  localparam int unsigned W_WIDTH    = 8;
  localparam int unsigned MULT_WIDTH = 16;

  typedef logic        [F_WIDTH-1:0]    f_t;
  typedef logic signed [W_WIDTH-1:0]    w_t;
  typedef logic signed [MULT_WIDTH-1:0] mult_t;

endpackage

// File: rtl/mult_array.sv
// Structural shift-add multiplier: unsigned feature times signed weight, optional pipelining.
module mult_array
  import aegnn::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  f_t    feature,
  input  w_t    weight,
  output mult_t product
);

  // One stage sits after the partial products once there are two or more stages.
  localparam int unsigned OutStages = (LATENCY >= 2) ? LATENCY - 1 : LATENCY;

  logic [W_WIDTH-1:0][F_WIDTH-1:0] pp;
  logic [W_WIDTH-1:0][F_WIDTH-1:0] pp_s;
  mult_t                           term [W_WIDTH];
  mult_t                           lvl1 [4];
  mult_t                           sum;

  always_comb begin
    for (int i = 0; i < W_WIDTH; i++) begin
      pp[i] = feature & {F_WIDTH{weight[i]}};
    end
  end

  if (LATENCY >= 2) begin : g_pp_reg
    logic [W_WIDTH-1:0][F_WIDTH-1:0] pp_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        pp_q <= '0;
      end else begin
        pp_q <= pp;
      end
    end
    assign pp_s = pp_q;
  end else begin : g_pp_comb
    assign pp_s = pp;
  end

  // The MSB partial product carries weight -2^7, so it is subtracted.
  always_comb begin
    for (int i = 0; i < W_WIDTH; i++) begin
      term[i] = mult_t'(pp_s[i]) << i;
    end
    lvl1[0] = term[0] + term[1];
    lvl1[1] = term[2] + term[3];
    lvl1[2] = term[4] + term[5];
    lvl1[3] = term[6] - term[7];
    sum     = (lvl1[0] + lvl1[1]) + (lvl1[2] + lvl1[3]);
  end

  if (OutStages == 0) begin : g_out_comb
    assign product = sum;
  end else begin : g_out_reg
    mult_t out_q [OutStages];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < OutStages; i++) out_q[i] <= '0;
      end else begin
        out_q[0] <= sum;
        for (int i = 1; i < OutStages; i++) out_q[i] <= out_q[i-1];
      end
    end
    assign product = out_q[OutStages-1];
  end

endmodule

// File: rtl/mult_gnn.sv
// Feature-by-weight multiplier with selectable behavioural or shift-add implementation.
module mult_gnn
  import aegnn::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter string       DEVICE  = "code"
) (
  input  logic  clk,
  input  logic  rst,
  input  f_t    feature,
  input  w_t    weight,
  output mult_t product
);

  if (LATENCY > 4) begin : g_bad_latency
    $error("mult_gnn: LATENCY %0d outside 0..4", LATENCY);
  end

  if (DEVICE == "code") begin : g_code
    mult_t full;
    // Zero-extend feature, sign-extend weight; 16 bits hold every result exactly.
    assign full = mult_t'(feature) * mult_t'(weight);

    if (LATENCY == 0) begin : g_comb
      assign product = full;
    end else begin : g_pipe
      mult_t pipe_q [LATENCY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= full;
          for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign product = pipe_q[LATENCY-1];
    end
  end else if (DEVICE == "ip") begin : g_ip
    mult_array #(
      .LATENCY(LATENCY)
    ) u_mult_array (
      .clk    (clk),
      .rst    (rst),
      .feature(feature),
      .weight (weight),
      .product(product)
    );
  end else begin : g_bad_device
    $error("mult_gnn: unknown DEVICE \"%s\"", DEVICE);
    assign product = '0;
  end

endmodule

// File: tb/tb_mult_gnn.sv
// Scoreboard bench: both implementations at latencies 0, 1, 2 and 4 against an integer model.
module tb_mult_gnn;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  feature;
  logic [7:0]  weight;
  logic [15:0] prod_c [4];
  logic [15:0] prod_i [4];

  int unsigned lat [4] = '{0, 1, 2, 4};
  logic [15:0] exp_q [4][$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_gnn #(.LATENCY(0), .DEVICE("code")) u_c0 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_c[0]));
  mult_gnn #(.LATENCY(1), .DEVICE("code")) u_c1 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_c[1]));
  mult_gnn #(.LATENCY(2), .DEVICE("code")) u_c2 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_c[2]));
  mult_gnn #(.LATENCY(4), .DEVICE("code")) u_c4 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_c[3]));
  mult_gnn #(.LATENCY(0), .DEVICE("ip")) u_i0 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_i[0]));
  mult_gnn #(.LATENCY(1), .DEVICE("ip")) u_i1 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_i[1]));
  mult_gnn #(.LATENCY(2), .DEVICE("ip")) u_i2 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_i[2]));
  mult_gnn #(.LATENCY(4), .DEVICE("ip")) u_i4 (
    .clk(clk), .rst(rst), .feature(feature), .weight(weight), .product(prod_i[3]));

  function automatic logic [15:0] ref_mul(input logic [7:0] f, input logic [7:0] w);
    int p;
    p = int'(f) * int'($signed(w));
    return p[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d (%h) want %0d (%h)", tag, $signed(got), got,
               $signed(want), want);
    end
  endtask

  // Reset clears every register in flight, so pending expectations become zero.
  task automatic drive(input logic [7:0] f, input logic [7:0] w, input logic r);
    feature = f;
    weight  = w;
    rst     = r;
    for (int k = 0; k < 4; k++) begin
      if (r && lat[k] != 0) begin
        for (int i = 0; i < exp_q[k].size(); i++) exp_q[k][i] = '0;
        exp_q[k].push_back('0);
      end else begin
        exp_q[k].push_back(ref_mul(f, w));
      end
    end
  endtask

  task automatic check_outputs();
    logic [15:0] e;
    int unsigned need;
    for (int k = 0; k < 4; k++) begin
      need = (lat[k] == 0) ? 1 : lat[k];
      if (exp_q[k].size() == need) begin
        e = exp_q[k].pop_front();
        chk($sformatf("code_l%0d", lat[k]), prod_c[k], e);
        chk($sformatf("ip_l%0d", lat[k]), prod_i[k], e);
      end
    end
  endtask

  task automatic step(input logic [7:0] f, input logic [7:0] w, input logic r);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    drive(f, w, r);
  endtask

  initial begin
    drive(8'd0, 8'd0, 1'b1);
    step(8'd17, 8'd99, 1'b1);
    step(8'd42, 8'd200, 1'b1);
    step(8'd5, 8'd5, 1'b1);
    // Directed corners and back-to-back changes.
    step(8'd255, 8'h80, 1'b0);
    step(8'd128, 8'd127, 1'b0);
    step(8'd2, 8'd4, 1'b0);
    step(8'd0, 8'hFF, 1'b0);
    step(8'd255, 8'hFF, 1'b0);
    step(8'd1, 8'h80, 1'b0);
    step(8'd255, 8'd127, 1'b0);
    // Two operands in flight, then a one-cycle reset.
    step(8'd100, 8'd50, 1'b0);
    step(8'd200, 8'hFD, 1'b0);
    step(8'd7, 8'd7, 1'b1);
    step(8'd3, 8'd3, 1'b0);
    step(8'd9, 8'hF0, 1'b0);
    for (int f = 0; f < 256; f++) begin
      for (int w = 0; w < 256; w++) begin
        step(8'(f), 8'(w), 1'b0);
      end
    end
    for (int i = 0; i < 6; i++) step(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_gnn.md
MULT_GNN -- requirements
Module: mult_gnn

Interface
REQ-001 Parameter LATENCY, default 2, number of register stages from inputs to product; legal range 0..4.
REQ-002 Parameter DEVICE, default "code", implementation select: "code" = behavioural multiply, "ip" = structural shift-add array.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 feature  input  f_t (8)  unsigned node feature, 0..255.
REQ-006 weight  input  w_t (8)  signed two's-complement weight, -128..127.
REQ-007 product  output  mult_t (16)  signed two's-complement feature*weight.

Function
REQ-008 product SHALL equal the exact signed product of zero-extended feature and sign-extended weight, truncated to 16 bits.
REQ-009 Truncation SHALL be lossless for all input pairs; full result range is -32640..32385.
REQ-010 No saturation, rounding or overflow flag SHALL be implemented.
REQ-011 For LATENCY = L >= 1, inputs sampled at rising edge e SHALL appear on product immediately after edge e+L-1 and hold until the next edge.
REQ-012 For LATENCY = 0, product SHALL be purely combinational from feature and weight; rst SHALL have no effect.
REQ-013 The pipeline SHALL accept new operands every cycle (initiation interval 1), with no stall, valid or handshake signals.
REQ-014 DEVICE "code" and DEVICE "ip" SHALL produce bit-identical product sequences for identical input and reset sequences at equal LATENCY.
REQ-015 In "ip" mode, partial products SHALL be formed as feature AND-gated by each weight bit.
REQ-016 In "ip" mode, the weight MSB partial product SHALL be subtracted (two's-complement weighting), and the partial products summed by an adder tree.
REQ-017 In "ip" mode, registers SHALL be placed after the partial-product stage for L >= 2, with the remaining L-1 stages retimed at the output.
REQ-018 Any DEVICE value other than "code"/"ip", or LATENCY outside 0..4, SHALL cause an elaboration-time error.

Reset
REQ-019 When rst is high at a rising edge, every pipeline register SHALL clear to 0, so product = 0 after that edge (L >= 1).
REQ-020 Operands present while rst is high SHALL be discarded.
REQ-021 After rst deasserts, product SHALL remain 0 until the first post-reset operand emerges L-1 edges after its sampling edge.
REQ-022 Reset asserted mid-pipeline SHALL flush all in-flight products; none SHALL appear after reset.
REQ-023 Before the first reset, product value is don't-care; no initial-value dependence is permitted.

Structure
REQ-024 Package aegnn SHALL hold f_t (logic [7:0]), w_t (logic signed [7:0]), mult_t (logic signed [15:0]), and width constants F_WIDTH=8, W_WIDTH=8, MULT_WIDTH=16.
REQ-025 The "ip" datapath SHALL be a single sub-module, mult_array, with the same clk/rst/feature/weight/product ports and the LATENCY parameter.
REQ-026 mult_gnn SHALL select between the behavioural path and mult_array with a generate on DEVICE.

Verification
REQ-027 Bench: feature=255, weight=-128 -> product = -32640 (16'h8080) exactly L cycles of register delay later, in both DEVICE modes.
REQ-028 Bench: feature=128, weight=127 -> 16256; feature=2, weight=4 -> 8; feature=0, weight=-1 -> 0; both instances identical every cycle.
REQ-029 Bench: back-to-back operand changes every cycle (255/-1, 1/-128, 255/127) -> products -255, -128, 32385 on consecutive cycles, with no bubbles.
REQ-030 Bench: assert rst for one cycle while two operands are in flight (L=2) -> product = 0 after the reset edge, and the flushed values never appear.
REQ-031 Bench: exhaustive sweep of all 65536 operand pairs for L = 0, 1, 2, 4 in both modes, compared against a reference model -> zero mismatches.
REQ-032 Bench: DEVICE="dsp" or LATENCY=5 -> elaboration fails with an error.
